// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op_code encodings, the zero
// register address, the ID/EX payload struct and the forwarding-hit helper.
package cpu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned SHAMT_W = 5;

    // ALU op_code encodings
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(12);

    // op_code inserted for bubbles; the ALU produces 0 for it
    localparam logic [OP_W-1:0] NOP_OP = OP_NOP;

    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op_code;
        logic [SHAMT_W-1:0] shamt;
        logic               reg_write;
        logic               mem_read;
        logic [RADDR_W-1:0] rd_addr;
        logic [RADDR_W-1:0] rs_addr;
        logic [RADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
    } id_ex_t;

    // Empty slot: everything zero except the ALU nop op_code
    function automatic id_ex_t bubble();
        id_ex_t b;
        b         = '0;
        b.op_code = NOP_OP;
        return b;
    endfunction

    // A writing producer forwards to a consumer address unless it targets r0
    function automatic logic fwd_hit(input logic               we,
                                     input logic [RADDR_W-1:0] src_addr,
                                     input logic [RADDR_W-1:0] dst_addr);
        return we && (src_addr != REG_ZERO) && (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode, the forwarding sources and the ID/EX stage.
//   master: decode / hazard-control / EX-MEM / MEM-WB side (drives id_*,
//           stall, flush, exmem_*, memwb_*; observes the ALU-facing outputs)
//   slave : the ID/EX stage itself
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic               id_valid;
    logic [DATA_W-1:0]  id_rs_data;
    logic [DATA_W-1:0]  id_rt_data;
    logic [RADDR_W-1:0] id_rs_addr;
    logic [RADDR_W-1:0] id_rt_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic [OP_W-1:0]    id_op_code;
    logic [SHAMT_W-1:0] id_shamt;
    logic               id_reg_write;
    logic               id_mem_read;

    logic               stall;
    logic               flush;

    logic               exmem_reg_write;
    logic [RADDR_W-1:0] exmem_rd_addr;
    logic [DATA_W-1:0]  exmem_result;
    logic               memwb_reg_write;
    logic [RADDR_W-1:0] memwb_rd_addr;
    logic [DATA_W-1:0]  memwb_result;

    logic [DATA_W-1:0]  alu_reg1;
    logic [DATA_W-1:0]  alu_reg2;
    logic [OP_W-1:0]    alu_op_code;
    logic [SHAMT_W-1:0] alu_shamt;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_valid;
    logic               load_use_stall;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
               id_rd_addr, id_op_code, id_shamt, id_reg_write, id_mem_read,
               stall, flush,
               exmem_reg_write, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result,
        input  alu_reg1, alu_reg2, alu_op_code, alu_shamt,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_valid, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
               id_rd_addr, id_op_code, id_shamt, id_reg_write, id_mem_read,
               stall, flush,
               exmem_reg_write, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result,
        output alu_reg1, alu_reg2, alu_op_code, alu_shamt,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_valid, load_use_stall
    );

endinterface

// File: rtl/fwd_mux.sv
// Single-operand forwarding selector.
//   operand_addr / stored_data : register address and value held in ID/EX
//   exmem_* / memwb_*          : later-stage producers
//   operand_c                  : operand the ALU should use (combinational)
// EX/MEM is the younger producer, so it wins when both match.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RADDR_W-1:0] operand_addr,
    input  logic [DATA_W-1:0]  stored_data,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  operand_c
);

    // Priority select: EX/MEM, then MEM/WB, then the stored register value
    always_comb begin
        operand_c = stored_data;
        if (fwd_hit(exmem_reg_write, exmem_rd_addr, operand_addr)) begin
            operand_c = exmem_result;
        end else if (fwd_hit(memwb_reg_write, memwb_rd_addr, operand_addr)) begin
            operand_c = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding,
// load-use hazard detection, downstream stall and branch/jump flush.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of id_ex_stage_if (decode inputs, stall/flush,
//              forwarding sources in; ALU operands, ex_* fields and
//              load_use_stall out)
// alu_reg1/alu_reg2 and load_use_stall are combinational; every other
// output is taken directly from the pipeline register.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    id_ex_t q;
    id_ex_t d;
    id_ex_t captured;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              lu_hazard;

    // Forwarded operands for rs and rt
    fwd_mux u_fwd_rs (
        .operand_addr    (q.rs_addr),
        .stored_data     (q.rs_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd_addr   (bus.exmem_rd_addr),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd_addr   (bus.memwb_rd_addr),
        .memwb_result    (bus.memwb_result),
        .operand_c       (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .operand_addr    (q.rt_addr),
        .stored_data     (q.rt_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd_addr   (bus.exmem_rd_addr),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd_addr   (bus.memwb_rd_addr),
        .memwb_result    (bus.memwb_result),
        .operand_c       (fwd_rt)
    );

    // Load in EX whose destination is read by the instruction in decode.
    // Masked during stall/flush: the decode slot is not advancing anyway.
    always_comb begin
        lu_hazard = 1'b0;
        if (q.valid && q.mem_read && (q.rd_addr != REG_ZERO) && bus.id_valid &&
            ((q.rd_addr == bus.id_rs_addr) || (q.rd_addr == bus.id_rt_addr))) begin
            lu_hazard = !bus.stall && !bus.flush;
        end
    end

    // Decode-stage fields as they would be captured
    always_comb begin
        captured           = '0;
        captured.valid     = bus.id_valid;
        captured.op_code   = bus.id_op_code;
        captured.shamt     = bus.id_shamt;
        captured.reg_write = bus.id_reg_write;
        captured.mem_read  = bus.id_mem_read;
        captured.rd_addr   = bus.id_rd_addr;
        captured.rs_addr   = bus.id_rs_addr;
        captured.rt_addr   = bus.id_rt_addr;
        captured.rs_data   = bus.id_rs_data;
        captured.rt_data   = bus.id_rt_data;
    end

    // Next-state selection: flush > stall > load-use bubble > capture.
    // A stall refreshes the operands so a producer retiring mid-stall
    // is not lost once it leaves the forwarding window.
    always_comb begin
        d = q;
        if (bus.flush) begin
            d = bubble();
        end else if (bus.stall) begin
            d.rs_data = fwd_rs;
            d.rt_data = fwd_rt;
        end else if (lu_hazard) begin
            d = bubble();
        end else begin
            d = captured;
        end
    end

    // Pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= bubble();
        end else begin
            q <= d;
        end
    end

    assign bus.alu_reg1       = fwd_rs;
    assign bus.alu_reg2       = fwd_rt;
    assign bus.alu_op_code    = q.op_code;
    assign bus.alu_shamt      = q.shamt;
    assign bus.ex_rd_addr     = q.rd_addr;
    assign bus.ex_reg_write   = q.reg_write;
    assign bus.ex_mem_read    = q.mem_read;
    assign bus.ex_valid       = q.valid;
    assign bus.load_use_stall = lu_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  op;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        v;
        logic        lus;
    } obs_t;

    logic clk;
    logic rst;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors    = 0;
    int    miscompares = 0;

    function automatic obs_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] op, input logic [4:0] shamt,
                                input logic [4:0] rd, input logic rw,
                                input logic mr, input logic v, input logic lus);
        obs_t o;
        o.r1 = r1; o.r2 = r2; o.op = op; o.shamt = shamt; o.rd = rd;
        o.rw = rw; o.mr = mr; o.v = v; o.lus = lus;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.r1    = bus.alu_reg1;
        o.r2    = bus.alu_reg2;
        o.op    = bus.alu_op_code;
        o.shamt = bus.alu_shamt;
        o.rd    = bus.ex_rd_addr;
        o.rw    = bus.ex_reg_write;
        o.mr    = bus.ex_mem_read;
        o.v     = bus.ex_valid;
        o.lus   = bus.load_use_stall;
        return o;
    endfunction

    task automatic expect_out(input string tag, input obs_t e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        obs_t  e;
        obs_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = sample();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed r1=%h r2=%h op=%0d sh=%0d rd=%0d rw=%b mr=%b v=%b lus=%b expected r1=%h r2=%h op=%0d sh=%0d rd=%0d rw=%b mr=%b v=%b lus=%b",
                   t, o.r1, o.r2, o.op, o.shamt, o.rd, o.rw, o.mr, o.v, o.lus,
                   e.r1, e.r2, e.op, e.shamt, e.rd, e.rw, e.mr, e.v, e.lus);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rs_d,
                          input logic [4:0] rt, input logic [31:0] rt_d,
                          input logic [4:0] rd, input logic [4:0] op,
                          input logic [4:0] sh, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rs_addr   = rs;
        bus.id_rs_data   = rs_d;
        bus.id_rt_addr   = rt;
        bus.id_rt_data   = rt_d;
        bus.id_rd_addr   = rd;
        bus.id_op_code   = op;
        bus.id_shamt     = sh;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    obs_t bub;

    initial begin
        bub = mk(32'h0, 32'h0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.exmem_reg_write = 1'b0; bus.exmem_rd_addr = 5'd0; bus.exmem_result = 32'h0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd_addr = 5'd0; bus.memwb_result = 32'h0;
        #1;
        expect_out("reset_state", bub);
        check_out();
        tick();
        tick();
        rst = 1'b0;

        // Basic capture
        set_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        expect_out("capture", mk(32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();

        // Forwarding priority on rs
        set_id(1'b1, 5'd4, 32'd1, 5'd0, 32'd2, 5'd5, 5'd1, 5'd3, 1'b1, 1'b0);
        expect_out("fwd_none", mk(32'd1, 32'd2, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd4; bus.exmem_result = 32'hAA;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd4; bus.memwb_result = 32'hBB;
        expect_out("fwd_exmem_wins", mk(32'hAA, 32'd2, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        bus.exmem_reg_write = 1'b0;
        expect_out("fwd_memwb", mk(32'hBB, 32'd2, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd0; bus.memwb_rd_addr = 5'd0;
        expect_out("fwd_r0_never", mk(32'd1, 32'd2, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        bus.memwb_rd_addr = 5'd4;
        expect_out("fwd_memwb_exmem_r0", mk(32'hBB, 32'd2, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        bus.exmem_reg_write = 1'b0; bus.memwb_reg_write = 1'b0;

        // Load-use hazard
        set_id(1'b1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1);
        expect_out("load_capture", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        tick();
        check_out();
        set_id(1'b1, 5'd3, 32'h30, 5'd8, 32'h40, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0);
        expect_out("lu_stall_on", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1));
        #1 check_out();
        expect_out("lu_bubble", bub);
        tick();
        check_out();
        expect_out("lu_resume", mk(32'h30, 32'h40, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();

        // Load to r0 never stalls
        set_id(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        expect_out("load_r0_capture", mk(32'h11, 32'h22, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        tick();
        check_out();
        set_id(1'b1, 5'd0, 32'h33, 5'd0, 32'h44, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0);
        expect_out("lu_r0_no_stall", mk(32'h11, 32'h22, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 check_out();

        // Load-use masked by a downstream stall
        set_id(1'b1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1);
        expect_out("load2_capture", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        tick();
        check_out();
        set_id(1'b1, 5'd8, 32'h50, 5'd3, 32'h60, 5'd4, 5'd1, 5'd0, 1'b1, 1'b0);
        bus.stall = 1'b1;
        expect_out("lu_masked_by_stall", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 check_out();
        bus.stall = 1'b0;
        expect_out("lu_rs_match", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1));
        #1 check_out();
        expect_out("lu_rs_bubble", bub);
        tick();
        check_out();

        // Stall refresh keeps a producer that retires mid-stall
        set_id(1'b1, 5'd9, 32'h0, 5'd0, 32'h4, 5'd6, 5'd3, 5'd0, 1'b1, 1'b0);
        expect_out("refresh_capture", mk(32'h0, 32'h4, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();
        bus.stall = 1'b1;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd9; bus.memwb_result = 32'h55;
        set_id(1'b1, 5'd1, 32'h99, 5'd2, 32'h98, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
        expect_out("stall_c1_fwd", mk(32'h55, 32'h4, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        tick();
        bus.memwb_reg_write = 1'b0;
        expect_out("stall_c2_kept", mk(32'h55, 32'h4, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0));
        #1 check_out();
        expect_out("stall_c2_held", mk(32'h55, 32'h4, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();
        bus.stall = 1'b0;

        // Flush beats stall and masks load-use
        set_id(1'b1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1);
        expect_out("load3_capture", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        tick();
        check_out();
        set_id(1'b1, 5'd3, 32'h30, 5'd8, 32'h40, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        expect_out("flush_masks_lu", mk(32'h10, 32'h20, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 check_out();
        expect_out("flush_bubble", bub);
        tick();
        check_out();
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Asynchronous reset between edges
        set_id(1'b1, 5'd1, 32'h77, 5'd2, 32'h88, 5'd5, 5'd4, 5'd7, 1'b1, 1'b0);
        expect_out("pre_reset", mk(32'h77, 32'h88, 5'd4, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();
        #2;
        rst = 1'b1;
        expect_out("async_reset", bub);
        #1 check_out();
        tick();
        rst = 1'b0;
        expect_out("post_reset_capture", mk(32'h77, 32'h88, 5'd4, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register that directly feeds the ALU. It captures decoded operands and control from the decode stage and applies EX/MEM and MEM/WB forwarding to the ALU operand outputs. It also detects load-use hazards and handles downstream stall and branch/jump flush. Its outputs drive the ALU's reg1, reg2, op_code and shamt inputs.

Parameters:
DATA_W, 32, operand/result width
RADDR_W, 5, register address width
OP_W, 5, ALU op_code width
NOP_OP, 12, ALU op_code inserted for bubbles (ALU nop, result 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  decode stage holds a real instruction
id_rs_data  in  DATA_W  register-file read data, rs
id_rt_data  in  DATA_W  register-file read data, rt
id_rs_addr  in  RADDR_W  rs address
id_rt_addr  in  RADDR_W  rt address
id_rd_addr  in  RADDR_W  destination address
id_op_code  in  OP_W  ALU operation
id_shamt  in  5  shift amount
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
stall  in  1  downstream hold; stage keeps its contents
flush  in  1  discard the instruction being captured
exmem_reg_write  in  1  EX/MEM writes back
exmem_rd_addr  in  RADDR_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes back
memwb_rd_addr  in  RADDR_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
alu_reg1  out  DATA_W  forwarded rs operand to ALU
alu_reg2  out  DATA_W  forwarded rt operand to ALU
alu_op_code  out  OP_W  ALU op_code
alu_shamt  out  5  ALU shift amount
ex_rd_addr  out  RADDR_W  destination carried to EX/MEM
ex_reg_write  out  1  write-enable carried forward
ex_mem_read  out  1  load flag carried forward
ex_valid  out  1  stage holds a real instruction
load_use_stall  out  1  request that PC and IF/ID hold this cycle

Behaviour:
- rst is asynchronous and active-high. While asserted, all stored fields are 0 except op_code=NOP_OP. Consequences: alu_reg1=alu_reg2=0, ex_valid=0, load_use_stall=0.
- Bubble: valid=0, op_code=NOP_OP, reg_write=0, mem_read=0, rd/rs/rt addr=0, data=0, shamt=0.
- Update priority at each rising edge:
  1. flush: load a bubble.
  2. stall: hold all fields, but refresh stored rs/rt data with the current forwarded values (alu_reg1/alu_reg2). This keeps a producer that retires during the stall from being lost.
  3. load_use_stall: load a bubble.
  4. Otherwise: capture all id_* fields, with valid=id_valid.
- Latency: one cycle from id_* to the ALU-facing outputs.
- Forwarding is combinational on the stored fields, evaluated separately for rs (alu_reg1) and rt (alu_reg2):
  - if exmem_reg_write and exmem_rd_addr!=0 and exmem_rd_addr==stored addr, select exmem_result;
  - else if memwb_reg_write and memwb_rd_addr!=0 and memwb_rd_addr==stored addr, select memwb_result;
  - else select the stored data.
  - EX/MEM wins when both match. Address 0 never forwards.
- load_use_stall is combinational. It is 1 when all of the following hold: ex_valid, ex_mem_read, ex_rd_addr!=0, id_valid, and ex_rd_addr equals id_rs_addr or id_rt_addr.
  - It is forced to 0 while stall or flush is asserted.
- alu_op_code, alu_shamt and the ex_* outputs come straight from registers with no combinational path from id_*.
- Data widths are unchanged: no sign or zero extension happens in this block.

Decomposition:
- Shared package (cpu_pkg): DATA_W, RADDR_W, OP_W, the ALU op_code constants (ADD=0 through NOP=12), and the REG_ZERO address constant.
- One natural sub-module, fwd_mux: a single-operand forwarding selector instantiated twice (rs, rt).
- The hazard compare and the pipeline register stay in the top module.

Test Plan:
- Reset: assert rst mid-instruction, asynchronously between edges -> outputs immediately show op_code=12, alu_reg1=alu_reg2=0, ex_valid=0.
- Capture: id_rs_data=5, id_rt_data=7, op=0, rd=3, no forwarding -> next cycle alu_reg1=5, alu_reg2=7, alu_op_code=0, ex_rd_addr=3, ex_valid=1.
- Forward priority: stored rs_addr=4 and data=1; exmem (rd=4, result=0xAA) and memwb (rd=4, result=0xBB) both writing -> alu_reg1=0xAA. Drop exmem_reg_write -> 0xBB. Set rd=0 on both -> 1.
- Load-use: ex holds a load with rd=8; id_rt_addr=8, id_valid=1 -> load_use_stall=1 and the next cycle is a bubble (op=12, ex_valid=0). Repeat with rd=0 -> no stall.
- Stall refresh: stored rs=9 and data=0; hold stall 2 cycles while memwb writes rd=9, result=0x55 in cycle 1 only -> in cycle 2 alu_reg1 remains 0x55.
- Flush priority: flush and stall together, with a valid instruction stored -> next cycle bubble, ex_reg_write=0, load_use_stall=0 during flush.
